// File: rtl/image_crop_stream.sv
`default_nettype none
// ============================================================================
// Module      : image_crop_stream
// Description : Streaming crop stage ahead of the CNN core. Accepts a full
//               IN_ROWS x IN_COLS raster stream and forwards only the
//               OUT_ROWS x OUT_COLS window whose top-left corner is the
//               clamped (crop_y1, crop_x1) origin latched at ap_start.
//               Optional macro CROP_TLAST_EN adds out_TLAST on the final
//               window pixel.
// Revision    : 1.0 - initial release
// ============================================================================
module image_crop_stream #(
    parameter int FP_TOTAL = 16,
    parameter int IN_ROWS  = 100,
    parameter int IN_COLS  = 160,
    parameter int OUT_ROWS = 48,
    parameter int OUT_COLS = 48
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst,
    input  logic                       ap_start,
    output logic                       ap_done,
    output logic                       ap_idle,
    output logic                       ap_ready,
    input  logic [$clog2(IN_ROWS)-1:0] crop_y1,
    input  logic [$clog2(IN_COLS)-1:0] crop_x1,
    input  logic [FP_TOTAL-1:0]        in_TDATA,
    input  logic                       in_TVALID,
    output logic                       in_TREADY,
    output logic [FP_TOTAL-1:0]        out_TDATA,
    output logic                       out_TVALID,
`ifdef CROP_TLAST_EN
    output logic                       out_TLAST,
`endif
    input  logic                       out_TREADY
);

    localparam int c_RW = $clog2(IN_ROWS);
    localparam int c_CW = $clog2(IN_COLS);

    localparam logic [c_RW-1:0] c_Y1_MAX   = c_RW'(IN_ROWS - OUT_ROWS);
    localparam logic [c_CW-1:0] c_X1_MAX   = c_CW'(IN_COLS - OUT_COLS);
    localparam logic [c_RW-1:0] c_ROW_LAST = c_RW'(IN_ROWS - 1);
    localparam logic [c_CW-1:0] c_COL_LAST = c_CW'(IN_COLS - 1);
    // Window extents are compared one bit wider so y1+OUT_ROWS cannot wrap.
    localparam logic [c_RW:0]   c_WIN_ROWS = (c_RW+1)'(OUT_ROWS);
    localparam logic [c_CW:0]   c_WIN_COLS = (c_CW+1)'(OUT_COLS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [c_RW-1:0]       row_q, y1_q;
    logic [c_CW-1:0]       col_q, x1_q;
    logic [FP_TOTAL-1:0]   data_q;
    logic                  valid_q;
`ifdef CROP_TLAST_EN
    logic                  last_q;
`endif

    logic                  w_in_hs;
    logic                  w_row_end;
    logic                  w_frame_end;
    logic                  w_in_win;
    logic                  w_win_last;
    logic [c_RW-1:0]       w_y1_clamp;
    logic [c_CW-1:0]       w_x1_clamp;

    assign in_TREADY   = (state_q == S_RUN) && (!valid_q || out_TREADY);
    assign w_in_hs     = in_TVALID && in_TREADY;
    assign w_row_end   = (col_q == c_COL_LAST);
    assign w_frame_end = (row_q == c_ROW_LAST) && w_row_end;

    assign w_y1_clamp  = (crop_y1 > c_Y1_MAX) ? c_Y1_MAX : crop_y1;
    assign w_x1_clamp  = (crop_x1 > c_X1_MAX) ? c_X1_MAX : crop_x1;

    assign w_in_win    = (row_q >= y1_q) && ({1'b0, row_q} < ({1'b0, y1_q} + c_WIN_ROWS)) &&
                         (col_q >= x1_q) && ({1'b0, col_q} < ({1'b0, x1_q} + c_WIN_COLS));
    assign w_win_last  = ({1'b0, row_q} == ({1'b0, y1_q} + c_WIN_ROWS - (c_RW+1)'(1))) &&
                         ({1'b0, col_q} == ({1'b0, x1_q} + c_WIN_COLS - (c_CW+1)'(1)));

    assign out_TDATA   = data_q;
    assign out_TVALID  = valid_q;
`ifdef CROP_TLAST_EN
    assign out_TLAST   = last_q;
`endif

    // State register for the block-level control FSM.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and block-level handshake outputs.
    always_comb begin
        state_d  = state_q;
        ap_idle  = 1'b0;
        ap_done  = 1'b0;
        ap_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) state_d = S_RUN;
            end
            S_RUN: begin
                if (w_in_hs && w_frame_end) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (!valid_q) state_d = S_DONE;
            end
            S_DONE: begin
                ap_done  = 1'b1;
                ap_ready = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Origin latch, raster counters and the single output register stage.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            row_q   <= '0;
            col_q   <= '0;
            y1_q    <= '0;
            x1_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
`ifdef CROP_TLAST_EN
            last_q  <= 1'b0;
`endif
        end else begin
            if ((state_q == S_IDLE) && ap_start) begin
                y1_q  <= w_y1_clamp;
                x1_q  <= w_x1_clamp;
                row_q <= '0;
                col_q <= '0;
            end

            // The row counter wraps at frame end so it never passes IN_ROWS-1.
            if (w_in_hs) begin
                if (w_row_end) begin
                    col_q <= '0;
                    row_q <= w_frame_end ? '0 : row_q + c_RW'(1);
                end else begin
                    col_q <= col_q + c_CW'(1);
                end
            end

            // Data only reloads on an in-window pixel, so it stays stable
            // while a beat is stalled downstream.
            if (w_in_hs) begin
                valid_q <= w_in_win;
                if (w_in_win) data_q <= in_TDATA;
`ifdef CROP_TLAST_EN
                last_q  <= w_in_win && w_win_last;
`endif
            end else if (out_TREADY) begin
                valid_q <= 1'b0;
`ifdef CROP_TLAST_EN
                last_q  <= 1'b0;
`endif
            end
        end
    end

`ifndef CROP_TLAST_EN
    // Only consumed when the last-beat flag is built in.
    logic w_unused_last;
    assign w_unused_last = w_win_last;
`endif

endmodule
`default_nettype wire

// File: tb/tb_image_crop_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_image_crop_stream
// Description : Self-checking bench for image_crop_stream. Pixels carry their
//               linear raster index; the reference crop is built from the
//               clamped origin as a queue of r*IN_COLS+c values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_image_crop_stream;

    localparam int IN_ROWS  = 100;
    localparam int IN_COLS  = 160;
    localparam int OUT_ROWS = 48;
    localparam int OUT_COLS = 48;
    localparam int N_PIX    = IN_ROWS * IN_COLS;
    localparam int N_OUT    = OUT_ROWS * OUT_COLS;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        ap_start;
    logic        ap_done, ap_idle, ap_ready;
    logic [6:0]  crop_y1;
    logic [7:0]  crop_x1;
    logic [15:0] in_TDATA;
    logic        in_TVALID, in_TREADY;
    logic [15:0] out_TDATA;
    logic        out_TVALID;
    logic        out_TREADY;
`ifdef CROP_TLAST_EN
    logic        out_TLAST;
`endif

    int vectors    = 0;
    int miscompares = 0;

    int gold[$];
    int r_first, r_last, r_nout, r_done;
    int r_tlast_cnt;

    always #5 ap_clk = ~ap_clk;

    image_crop_stream dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .ap_start  (ap_start),
        .ap_done   (ap_done),
        .ap_idle   (ap_idle),
        .ap_ready  (ap_ready),
        .crop_y1   (crop_y1),
        .crop_x1   (crop_x1),
        .in_TDATA  (in_TDATA),
        .in_TVALID (in_TVALID),
        .in_TREADY (in_TREADY),
        .out_TDATA (out_TDATA),
        .out_TVALID(out_TVALID),
`ifdef CROP_TLAST_EN
        .out_TLAST (out_TLAST),
`endif
        .out_TREADY(out_TREADY)
    );

    // Streams one frame and scoreboards every output beat against the
    // reference crop. Stops early once abort_at input pixels are accepted.
    task automatic run_frame(input int y, input int x, input int vpct, input int rpct,
                             input int stall_at, input int abort_at);
        int ye, xe, pix, cyc, stall_left;
        bit stalled, stalling, finished;
        logic [15:0] held, exp;
        ye = (y > IN_ROWS - OUT_ROWS) ? IN_ROWS - OUT_ROWS : y;
        xe = (x > IN_COLS - OUT_COLS) ? IN_COLS - OUT_COLS : x;
        gold.delete();
        for (int r = ye; r < ye + OUT_ROWS; r++)
            for (int c = xe; c < xe + OUT_COLS; c++)
                gold.push_back(r * IN_COLS + c);
        r_first = -1; r_last = -1; r_nout = 0; r_done = 0; r_tlast_cnt = 0;

        @(negedge ap_clk);
        crop_y1  = 7'(y);
        crop_x1  = 8'(x);
        ap_start = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b0;
        crop_y1  = 7'($urandom);
        crop_x1  = 8'($urandom);

        pix = 0; cyc = 0; stall_left = 0; stalled = 0; finished = 0; held = '0;
        while (!finished && cyc < 60000) begin
            in_TVALID = (pix < N_PIX) && ($urandom_range(99) < vpct);
            in_TDATA  = 16'(pix);
            stalling  = 0;
            if (stall_left > 0) begin
                stall_left--;
                stalling   = 1;
                out_TREADY = 1'b0;
            end else if (stall_at >= 0 && !stalled && r_nout == stall_at && out_TVALID) begin
                stalled    = 1;
                stall_left = 99;
                stalling   = 1;
                held       = out_TDATA;
                out_TREADY = 1'b0;
            end else begin
                out_TREADY = ($urandom_range(99) < rpct);
            end
            #1;
            if (stalling) begin
                vectors++;
                if (out_TDATA !== held || in_TREADY !== 1'b0) begin
                    miscompares++;
                    $display("FAIL stall_hold: out_TDATA=%0d in_TREADY=%b, required out_TDATA=%0d in_TREADY=0",
                             out_TDATA, in_TREADY, held);
                end
            end
            if (out_TVALID && out_TREADY) begin
                vectors++;
                if (gold.size() == 0) begin
                    miscompares++;
                    $display("FAIL extra_beat: out_TDATA=%0d, required no further output", out_TDATA);
                end else begin
                    exp = 16'(gold.pop_front());
                    if (out_TDATA !== exp) begin
                        miscompares++;
                        $display("FAIL out_beat%0d: out_TDATA=%0d, required %0d", r_nout, out_TDATA, exp);
                    end
`ifdef CROP_TLAST_EN
                    vectors++;
                    if (out_TLAST !== (gold.size() == 0)) begin
                        miscompares++;
                        $display("FAIL tlast_beat%0d: out_TLAST=%b, required %b", r_nout, out_TLAST, gold.size() == 0);
                    end
                    if (out_TLAST === 1'b1) r_tlast_cnt++;
`endif
                end
                if (r_nout == 0) r_first = int'(out_TDATA);
                r_last = int'(out_TDATA);
                r_nout++;
            end
            if (ap_done || ap_ready) begin
                vectors++;
                if (ap_done !== 1'b1 || ap_ready !== 1'b1 || gold.size() != 0) begin
                    miscompares++;
                    $display("FAIL done_pulse: ap_done=%b ap_ready=%b pending=%0d, required 1 1 0",
                             ap_done, ap_ready, gold.size());
                end
                r_done++;
                finished = 1;
            end
            if (in_TVALID && in_TREADY) pix++;
            @(negedge ap_clk);
            cyc++;
            if (abort_at > 0 && pix >= abort_at) break;
        end
        in_TVALID  = 1'b0;
        out_TREADY = 1'b0;
        if (abort_at == 0) begin
            vectors++;
            if (!finished) begin
                miscompares++;
                $display("FAIL frame_timeout: ap_done not seen after %0d cycles, required one pulse", cyc);
            end else if (ap_done !== 1'b0 || ap_idle !== 1'b1) begin
                miscompares++;
                $display("FAIL post_done: ap_done=%b ap_idle=%b, required 0 1", ap_done, ap_idle);
            end
        end
    endtask

    task automatic test_reset();
        ap_rst = 1'b1;
        repeat (3) @(negedge ap_clk);
        ap_rst = 1'b0;
        #1;
        vectors++;
        if ({ap_idle, ap_done, ap_ready, out_TVALID, in_TREADY} !== 5'b10000 || out_TDATA !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_state: idle/done/ready/ovalid/iready=%b out_TDATA=%0d, required 10000 and 0",
                     {ap_idle, ap_done, ap_ready, out_TVALID, in_TREADY}, out_TDATA);
        end
    endtask

    task automatic test_default_stall();
        run_frame(10, 10, 100, 100, 1000, 0);
        vectors++;
        if (r_nout != N_OUT || r_first != 1610 || r_last != 9177 || r_done != 1) begin
            miscompares++;
            $display("FAIL default_frame: count=%0d first=%0d last=%0d done=%0d, required %0d 1610 9177 1",
                     r_nout, r_first, r_last, r_done, N_OUT);
        end
`ifdef CROP_TLAST_EN
        vectors++;
        if (r_tlast_cnt != 1) begin
            miscompares++;
            $display("FAIL tlast_count: got %0d, required 1", r_tlast_cnt);
        end
`endif
    endtask

    task automatic test_random();
        run_frame(10, 10, 50, 50, -1, 0);
        vectors++;
        if (r_nout != N_OUT || r_done != 1) begin
            miscompares++;
            $display("FAIL random_frame: count=%0d done=%0d, required %0d 1", r_nout, r_done, N_OUT);
        end
    endtask

    task automatic test_clamp();
        run_frame(80, 150, 100, 100, -1, 0);
        vectors++;
        if (r_nout != N_OUT || r_first != 8432 || r_last != 15999) begin
            miscompares++;
            $display("FAIL clamp_frame: count=%0d first=%0d last=%0d, required %0d 8432 15999",
                     r_nout, r_first, r_last, N_OUT);
        end
    endtask

    task automatic test_abort_restart();
        bit seen_done;
        run_frame(10, 10, 100, 100, -1, 5000);
        ap_rst = 1'b1;
        @(negedge ap_clk);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        #1;
        vectors++;
        if (ap_idle !== 1'b1 || out_TVALID !== 1'b0 || in_TREADY !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_reset: idle=%b ovalid=%b iready=%b, required 1 0 0",
                     ap_idle, out_TVALID, in_TREADY);
        end
        seen_done = 0;
        repeat (50) begin
            @(negedge ap_clk);
            #1;
            if (ap_done === 1'b1) seen_done = 1;
        end
        vectors++;
        if (seen_done) begin
            miscompares++;
            $display("FAIL abort_no_done: ap_done seen=1, required 0");
        end
        run_frame(0, 0, 100, 100, -1, 0);
        vectors++;
        if (r_nout != N_OUT || r_first != 0 || r_last != 7567 || r_done != 1) begin
            miscompares++;
            $display("FAIL restart_frame: count=%0d first=%0d last=%0d done=%0d, required %0d 0 7567 1",
                     r_nout, r_first, r_last, r_done, N_OUT);
        end
    endtask

    initial begin
        ap_rst     = 1'b1;
        ap_start   = 1'b0;
        crop_y1    = '0;
        crop_x1    = '0;
        in_TDATA   = '0;
        in_TVALID  = 1'b0;
        out_TREADY = 1'b0;
        test_reset();
        test_default_stall();
        test_random();
        test_clamp();
        test_abort_restart();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/image_crop_stream.md
Name: image_crop_stream

Overview:
- Streaming crop stage that sits directly upstream of the CNN core (`myproject`).
- Consumes a full IN_ROWS x IN_COLS raster-order pixel stream over an AXI-Stream-style valid/ready handshake.
- Forwards only the OUT_ROWS x OUT_COLS window whose top-left corner is at (crop_y1, crop_x1); every other pixel is accepted and discarded.
- Output feeds the CNN input stream directly; ap_start/ap_done/ap_idle/ap_ready follow the same block-level protocol as the CNN core.

Parameters:
- FP_TOTAL, 16, pixel word width in bits
- IN_ROWS, 100, input frame rows
- IN_COLS, 160, input frame columns
- OUT_ROWS, 48, crop window rows
- OUT_COLS, 48, crop window columns

Ports:
- ap_clk  in  1  clock; all logic on rising edge
- ap_rst  in  1  synchronous, active-high reset
- ap_start  in  1  starts one frame; sampled only in IDLE
- ap_done  out  1  one-cycle pulse when the frame completes
- ap_idle  out  1  high while in IDLE
- ap_ready  out  1  one-cycle pulse, same cycle as ap_done
- crop_y1  in  $clog2(IN_ROWS)  window top row; latched on accepted ap_start
- crop_x1  in  $clog2(IN_COLS)  window left column; latched on accepted ap_start
- in_TDATA  in  FP_TOTAL  input pixel
- in_TVALID  in  1  input pixel valid
- in_TREADY  out  1  block can accept an input pixel
- out_TDATA  out  FP_TOTAL  cropped pixel
- out_TVALID  out  1  output pixel valid
- out_TREADY  in  1  downstream can accept an output pixel

Behaviour:
- Reset: state=IDLE, row/col counters=0, out_TVALID=0, out_TDATA=0, in_TREADY=0, ap_done=0, ap_ready=0, ap_idle=1. Reset mid-frame aborts the frame immediately; any pending output is dropped; no ap_done is issued.
- FSM states:
  - IDLE: ap_start=1 latches the origin and goes to RUN.
  - RUN: counters advance; RUN goes to DRAIN on the handshake of the last input pixel (row=IN_ROWS-1, col=IN_COLS-1).
  - DRAIN: waits for out_TVALID=0, then goes to DONE.
  - DONE: one cycle; asserts ap_done and ap_ready; returns to IDLE.
- Origin clamp at latch time:
  - y1_eff = min(crop_y1, IN_ROWS-OUT_ROWS)
  - x1_eff = min(crop_x1, IN_COLS-OUT_COLS)
- Window test: y1_eff <= row < y1_eff+OUT_ROWS and x1_eff <= col < x1_eff+OUT_COLS.
- Output is a single registered stage:
  - in_TREADY = (state==RUN) && (!out_TVALID || out_TREADY), combinational.
  - Input handshake (in_TVALID && in_TREADY): col increments; at IN_COLS-1, col wraps to 0 and row increments.
  - Handshake with an in-window pixel: out_TDATA <= in_TDATA and out_TVALID <= 1, on the next edge (latency 1 cycle).
  - Handshake with an out-of-window pixel, or output handshake with no new in-window pixel: out_TVALID <= 0.
  - Simultaneous output handshake and new in-window input: the register reloads and out_TVALID stays 1.
  - out_TDATA is held stable while out_TVALID=1 and out_TREADY=0.
- Throughput: 1 pixel/cycle under continuous valid/ready.
- Output count per frame: exactly OUT_ROWS*OUT_COLS words, in raster order.
- ap_start during RUN, DRAIN or DONE is ignored. crop_y1/crop_x1 changes after the latch have no effect.
- Counter widths are $clog2 of the dimensions. The row counter never exceeds IN_ROWS-1.

Optional Feature:
- Macro: CROP_TLAST_EN.
- Defined: adds output out_TLAST (1 bit). It is registered alongside out_TDATA and is 1 only on the final window pixel (row=y1_eff+OUT_ROWS-1, col=x1_eff+OUT_COLS-1). Reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Default origin (10,10), input pixel value = linear index, valid and ready held high: 2304 outputs; first = 1610, last = 9177; ap_done pulses once, after the last output handshake.
- out_TREADY low for 100 cycles mid-window: out_TDATA is held constant and in_TREADY=0 throughout; the sequence resumes with no loss or duplication.
- Random in_TVALID and out_TREADY (50%): output stream equals the golden crop, 2304 words, in order.
- crop_y1=80, crop_x1=150: clamped to (52,112); first output = 8432, last = 15999.
- ap_rst asserted after 5000 input pixels, then a fresh frame with origin (0,0): no ap_done from the aborted frame; new frame first output = 0, last = 7567.
- CROP_TLAST_EN defined, default origin: out_TLAST=1 only with out_TDATA=9177, in exactly 1 of 2304 beats.
